// File: rtl/perf_counter_unit_pkg.sv
// Shared definitions for the performance counter unit and the pipeline debug logic.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_FROZEN   = 2'd2
  } perf_state_e;

  localparam int SEL_WIDTH = 4;

  // Constants shared with the pipeline debug logic (ADDI x0,x0,0 is the canonical NOP).
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_PC = 32'h0000_0000;

endpackage

// File: rtl/perf_counter_unit_cell.sv
// One performance counter with clear, gated increment and sticky overflow.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int SATURATE      = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     inc,
  input  logic                     enable,
  output logic [COUNTER_WIDTH-1:0] value,
  output logic                     overflow
);

  logic [COUNTER_WIDTH-1:0] value_q, value_d;
  logic                     overflow_q, overflow_d;

  // Next value: clear beats increment; an increment from all-ones wraps or sticks.
  always_comb begin
    value_d    = value_q;
    overflow_d = overflow_q;
    if (clear) begin
      value_d    = '0;
      overflow_d = 1'b0;
    end else if (enable && inc) begin
      if (value_q == {COUNTER_WIDTH{1'b1}}) begin
        overflow_d = 1'b1;
        if (SATURATE != 0) begin
          value_d = value_q;
        end else begin
          value_d = '0;
        end
      end else begin
        value_d = value_q + COUNTER_WIDTH'(1);
      end
    end else begin
      value_d = value_q;
    end
  end

  // Counter and overflow registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      overflow_q <= overflow_d;
    end
  end

  assign value    = value_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Performance monitor: cycle counter plus NUM_EVENTS event counters, auto-freeze on
// end_PC retirement, and a registered one-cycle-latency read port.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS    = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int ADDRESS_BITS  = 20,
  parameter int SATURATE      = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [NUM_EVENTS-1:0]    events,
  input  logic                     retire_valid,
  input  logic [ADDRESS_BITS-1:0]  retire_PC,
  input  logic [ADDRESS_BITS-1:0]  end_PC,
  input  logic                     read_req,
  input  logic [SEL_WIDTH-1:0]     read_sel,
  output logic                     read_valid,
  output logic [COUNTER_WIDTH-1:0] read_data,
  output logic [NUM_EVENTS:0]      overflow,
  output logic                     counting,
  output logic                     done
);

  perf_state_e              state_q, state_d;
  logic                     done_q, done_d;
  logic                     read_valid_q, read_valid_d;
  logic [COUNTER_WIDTH-1:0] read_data_q, read_data_d;
  logic [COUNTER_WIDTH-1:0] values_s [NUM_EVENTS+1];
  logic [NUM_EVENTS:0]      ovf_s;
  logic [COUNTER_WIDTH-1:0] sel_data_s;
  logic                     end_match_s;
  logic                     enable_s;

  assign end_match_s = retire_valid && (retire_PC == end_PC);
  assign enable_s    = (state_q == ST_COUNTING);

  // Channel 0 counts every cycle; channel g counts events[g-1].
  for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cell
    logic inc_s;
    if (g == 0) begin : g_cycle
      assign inc_s = 1'b1;
    end else begin : g_event
      assign inc_s = events[g-1];
    end
    perf_counter_cell #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .SATURATE      (SATURATE)
    ) u_cell (
      .clock    (clock),
      .reset    (reset),
      .clear    (start),
      .inc      (inc_s),
      .enable   (enable_s),
      .value    (values_s[g]),
      .overflow (ovf_s[g])
    );
  end

  // FSM next state; start restarts from any state and outranks stop/end match.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COUNTING;
          done_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNTING: begin
        if (start) begin
          state_d = ST_COUNTING;
          done_d  = 1'b0;
        end else if (stop || end_match_s) begin
          state_d = ST_FROZEN;
          done_d  = 1'b1;
        end else begin
          state_d = ST_COUNTING;
        end
      end
      ST_FROZEN: begin
        if (start) begin
          state_d = ST_COUNTING;
          done_d  = 1'b0;
        end else begin
          state_d = ST_FROZEN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  // Read mux over pre-update counter values; out-of-range selects read as zero.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i <= NUM_EVENTS; i++) begin
      sel_data_s = (read_sel == SEL_WIDTH'(i)) ? values_s[i] : sel_data_s;
    end
    read_valid_d = read_req;
    if (read_req) begin
      read_data_d = sel_data_s;
    end else begin
      read_data_d = read_data_q;
    end
  end

  // State, done flag and read port registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      read_valid_q <= read_valid_d;
      read_data_q  <= read_data_d;
    end
  end

  assign read_valid = read_valid_q;
  assign read_data  = read_data_q;
  assign overflow   = ovf_s;
  assign counting   = (state_q == ST_COUNTING);
  assign done       = done_q;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench: two 8-bit instances (wrap and saturate) driven identically and
// compared against a plain-arithmetic reference model.
module tb_perf_counter_unit;

  localparam int NE = 4;
  localparam int CW = 8;
  localparam int AB = 20;

  logic          clock = 1'b0;
  logic          reset, start, stop, retire_valid, read_req;
  logic [NE-1:0] events;
  logic [AB-1:0] retire_PC, end_PC;
  logic [3:0]    read_sel;

  logic          rv_w, rv_s, cnt_w, cnt_s, done_w, done_s;
  logic [CW-1:0] rd_w, rd_s;
  logic [NE:0]   ovf_w, ovf_s;

  perf_counter_unit #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .ADDRESS_BITS(AB), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .events(events),
    .retire_valid(retire_valid), .retire_PC(retire_PC), .end_PC(end_PC),
    .read_req(read_req), .read_sel(read_sel), .read_valid(rv_w), .read_data(rd_w),
    .overflow(ovf_w), .counting(cnt_w), .done(done_w));

  perf_counter_unit #(.NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .ADDRESS_BITS(AB), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .events(events),
    .retire_valid(retire_valid), .retire_PC(retire_PC), .end_PC(end_PC),
    .read_req(read_req), .read_sel(read_sel), .read_valid(rv_s), .read_data(rd_s),
    .overflow(ovf_s), .counting(cnt_s), .done(done_s));

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 = wrap instance, 1 = saturate instance; slot 0 = cycles.
  int cnt [2][NE+1];
  bit ovf [2][NE+1];
  bit m_counting, m_done;
  logic [CW-1:0] q_w[$];
  logic [CW-1:0] q_s[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NE:0] ovf_vec(input int d);
    logic [NE:0] v = '0;
    for (int k = 0; k <= NE; k++) v[k] = ovf[d][k];
    return v;
  endfunction

  task automatic bump(input int d, input int k);
    cnt[d][k] = cnt[d][k] + 1;
    if (cnt[d][k] > 255) begin
      ovf[d][k] = 1'b1;
      cnt[d][k] = (d == 1) ? 255 : cnt[d][k] % 256;
    end
  endtask

  // Apply current inputs to the model, clock the DUTs, then check status outputs.
  task automatic step();
    if (reset) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k <= NE; k++) begin cnt[d][k] = 0; ovf[d][k] = 1'b0; end
      m_counting = 1'b0;
      m_done     = 1'b0;
    end else begin
      if (read_req) begin
        q_w.push_back((read_sel <= NE) ? CW'(cnt[0][read_sel]) : '0);
        q_s.push_back((read_sel <= NE) ? CW'(cnt[1][read_sel]) : '0);
      end
      if (start) begin
        for (int d = 0; d < 2; d++)
          for (int k = 0; k <= NE; k++) begin cnt[d][k] = 0; ovf[d][k] = 1'b0; end
        m_counting = 1'b1;
        m_done     = 1'b0;
      end else if (m_counting) begin
        for (int d = 0; d < 2; d++) begin
          bump(d, 0);
          for (int k = 1; k <= NE; k++) if (events[k-1]) bump(d, k);
        end
        if (stop || (retire_valid && retire_PC == end_PC)) begin
          m_counting = 1'b0;
          m_done     = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    chk("counting_w", 64'(cnt_w), 64'(m_counting));
    chk("counting_s", 64'(cnt_s), 64'(m_counting));
    chk("done_w", 64'(done_w), 64'(m_done));
    chk("done_s", 64'(done_s), 64'(m_done));
    chk("overflow_w", 64'(ovf_w), 64'(ovf_vec(0)));
    chk("overflow_s", 64'(ovf_s), 64'(ovf_vec(1)));
  endtask

  task automatic drive(input logic st, input logic sp, input logic [NE-1:0] ev,
                       input logic rv, input logic [AB-1:0] pc,
                       input logic rq, input logic [3:0] sel, input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b0; start = st; stop = sp; events = ev; retire_valid = rv;
      retire_PC = pc; read_req = rq; read_sel = sel;
      step();
    end
  endtask

  task automatic read_all();
    for (int s = 0; s <= NE + 1; s++) drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 4'(s), 1);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 4'd9, 1);
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 4'd0, 1);
  endtask

  // Monitor: every read_valid pulse is matched against the oldest expected read.
  always @(negedge clock) begin
    if (rv_w) begin
      if (q_w.size() == 0) chk("unexpected_read_w", 64'd1, 64'd0);
      else chk("read_data_w", 64'(rd_w), 64'(q_w.pop_front()));
    end
    if (rv_s) begin
      if (q_s.size() == 0) chk("unexpected_read_s", 64'd1, 64'd0);
      else chk("read_data_s", 64'(rd_s), 64'(q_s.pop_front()));
    end
  end

  initial begin
    end_PC = 20'h000b0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; events = '0; retire_valid = 1'b0;
    retire_PC = '0; read_req = 1'b0; read_sel = '0;
    step();
    step();
    chk("reset_read_valid", 64'(rv_w | rv_s), 64'd0);
    chk("reset_read_data", 64'({rd_w, rd_s}), 64'd0);

    // Basic count: 10 event cycles then stop with the event still high.
    drive(1'b1, 1'b0, 4'b0000, 1'b0, '0, 1'b0, 4'd0, 1);
    drive(1'b0, 1'b0, 4'b0001, 1'b0, '0, 1'b0, 4'd0, 10);
    drive(1'b0, 1'b1, 4'b0001, 1'b0, '0, 1'b0, 4'd0, 1);
    read_all();

    // Auto-stop on end_PC at cycle 7, later PCs ignored.
    drive(1'b1, 1'b0, 4'b0000, 1'b0, '0, 1'b0, 4'd0, 1);
    drive(1'b0, 1'b0, 4'b0100, 1'b1, 20'h00010, 1'b0, 4'd0, 6);
    drive(1'b0, 1'b0, 4'b0100, 1'b1, 20'h000b0, 1'b0, 4'd0, 1);
    drive(1'b0, 1'b0, 4'b1111, 1'b1, 20'h000b4, 1'b0, 4'd0, 3);
    drive(1'b0, 1'b0, 4'b1111, 1'b1, 20'h000b0, 1'b0, 4'd0, 2);
    read_all();

    // Overflow: events[1] high for 300 cycles.
    drive(1'b1, 1'b0, 4'b0000, 1'b0, '0, 1'b0, 4'd0, 1);
    drive(1'b0, 1'b0, 4'b0010, 1'b0, '0, 1'b0, 4'd0, 299);
    drive(1'b0, 1'b1, 4'b0010, 1'b0, '0, 1'b0, 4'd0, 1);
    read_all();

    // Read timing around value 5, then start+stop priority at 50.
    drive(1'b1, 1'b0, 4'b0000, 1'b0, '0, 1'b0, 4'd0, 1);
    drive(1'b0, 1'b0, 4'b1000, 1'b0, '0, 1'b0, 4'd0, 5);
    drive(1'b0, 1'b0, 4'b1000, 1'b0, '0, 1'b1, 4'd0, 1);
    drive(1'b0, 1'b0, 4'b1000, 1'b0, '0, 1'b1, 4'd9, 1);
    drive(1'b0, 1'b0, 4'b1000, 1'b0, '0, 1'b0, 4'd0, 43);
    drive(1'b1, 1'b1, 4'b1000, 1'b1, 20'h000b0, 1'b1, 4'd0, 1);
    read_all();

    // Reset mid-count; events ignored until the next start.
    reset = 1'b1; step();
    drive(1'b0, 1'b1, 4'b1111, 1'b1, 20'h000b0, 1'b0, 4'd0, 5);
    read_all();

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      start        = ($urandom_range(0, 59) == 0);
      stop         = ($urandom_range(0, 79) == 0);
      events       = NE'($urandom);
      retire_valid = $urandom_range(0, 1) == 1;
      retire_PC    = ($urandom_range(0, 49) == 0) ? end_PC : AB'($urandom);
      read_req     = $urandom_range(0, 1) == 1;
      read_sel     = 4'($urandom_range(0, 10));
      step();
    end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 4'd0, 2);
    chk("pending_reads_w", 64'(q_w.size()), 64'd0);
    chk("pending_reads_s", 64'(q_s.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_unit.md
Name: perf_counter_unit

Overview:
- Synthesizable, parametrised performance-monitoring unit for the RISC_V_Core pipeline.
- Counts elapsed cycles plus NUM_EVENTS event strobes from the core (stall, flush, branch/jump taken, and others).
- Freezes all counts automatically when a retiring instruction's PC matches a programmable end address.
- Exposes counters through a one-cycle-latency read port, so software or a debug bridge can read the figures that were previously only available in simulation.

Parameters:
- NUM_EVENTS, 4, number of event counter channels (1..15).
- COUNTER_WIDTH, 32, width of every counter (8..64).
- ADDRESS_BITS, 20, width of PC inputs.
- SATURATE, 0, overflow mode: 0 = wrap to zero, 1 = hold at all-ones.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse: clear all counters and begin counting.
- stop  input  1  pulse: freeze counters.
- events  input  NUM_EVENTS  per-cycle event strobes; bit i increments channel i+1.
- retire_valid  input  1  an instruction is in writeback this cycle.
- retire_PC  input  ADDRESS_BITS  PC of the retiring instruction.
- end_PC  input  ADDRESS_BITS  auto-stop address.
- read_req  input  1  read request.
- read_sel  input  4  0 = cycle counter, 1..NUM_EVENTS = event channels.
- read_valid  output  1  read data valid, one-cycle pulse.
- read_data  output  COUNTER_WIDTH  selected counter value.
- overflow  output  NUM_EVENTS+1  sticky per-counter overflow; bit 0 = cycle counter.
- counting  output  1  high while in COUNTING.
- done  output  1  sticky; end_PC reached or stop received.

Behaviour:
- Reset (reset and clock as decided: reset reset, synchronous, active-high; clock clock):
  - state IDLE; all counters 0.
  - overflow, done, counting, read_valid and read_data all 0.
  - Reset mid-count discards all counts.
- States: IDLE, COUNTING, FROZEN. Encoding is 2-bit, held in the package.
- IDLE:
  - Counters hold.
  - start -> clear counters and overflow; next state COUNTING.
  - stop and end_PC match are ignored.
- COUNTING (counting = 1):
  - Cycle counter increments by 1 every cycle.
  - Channel i+1 increments by 1 in every cycle where events[i] = 1.
  - stop, or (retire_valid and retire_PC == end_PC), -> FROZEN. Events and the cycle in the transition cycle are still counted.
  - done = 1 from the next cycle.
- FROZEN:
  - Counters hold; done = 1.
  - start -> clear counters, overflow and done; next state COUNTING.
- Latency: start sampled at edge N -> counting = 1 and counters = 0 after edge N; first increment applied at edge N+1.
- Simultaneous events:
  - start together with stop or an end_PC match in any state: start wins (restart).
  - An end_PC match while FROZEN has no effect.
- Overflow:
  - Increment from all-ones sets the sticky overflow bit.
  - SATURATE = 0: counter wraps to 0.
  - SATURATE = 1: counter stays at all-ones and further increments are dropped.
  - Overflow bits clear only on start or reset.
- Read:
  - read_req sampled at edge N -> read_valid = 1 for exactly one cycle after edge N.
  - read_data is the value held before edge N's update (pre-increment, pre-clear).
  - read_sel > NUM_EVENTS: read_valid = 1 with read_data = 0.
  - Back-to-back reads are allowed, one per cycle.
  - read_data holds its last value when read_valid = 0.
- Arithmetic is unsigned, modulo 2^COUNTER_WIDTH, with no combinational path from events to read_data.

Decomposition:
- Package perf_pkg: state encoding constants (IDLE = 0, COUNTING = 1, FROZEN = 2), the SEL_WIDTH = 4 constant, and the NOP/default constants shared with pipeline debug logic.
- Sub-module perf_counter_cell: one counter with inputs clear, inc, enable; outputs value and overflow; parameters COUNTER_WIDTH and SATURATE.
- The top level instantiates NUM_EVENTS+1 cells and adds the FSM, the end_PC comparator and the read mux/register.

Test Plan:
- Basic count: reset, start, 10 cycles with events = 4'b0001 every cycle, then stop -> cycle counter = 11, channel 1 = 11, channels 2..4 = 0, done = 1, counting = 0.
- Auto-stop: end_PC = 20'h000b0, retire_valid with retire_PC = 20'h000b0 at cycle 7 after start -> FROZEN; cycle counter = 7; retire_PC changes afterwards leave values unchanged.
- Overflow: COUNTER_WIDTH = 8, events[1] held high for 300 cycles:
  - SATURATE = 0 -> channel 2 = 44, overflow[2] = 1.
  - SATURATE = 1 -> channel 2 = 255, overflow[2] = 1.
- Read timing: read_req with read_sel = 0 on the same edge as counter value 5 -> 5 -> read_valid and read_data = 5 the next cycle; read_sel = 9 with NUM_EVENTS = 4 -> read_data = 0, read_valid = 1.
- Priority: start and stop asserted together while COUNTING with counters at 50 -> counters = 0, counting = 1, done = 0.
- Reset mid-operation: reset during COUNTING with counters non-zero -> all outputs 0 and state IDLE next cycle; events are ignored until start.
